// File: rtl/rx_correlator_buff_reader_if.sv
// Handshake and data signals between the ping-pong buffer reader, its BRAM and its consumer.
// The slave modport is the reader. The master modport is the surrounding logic.
interface rx_correlator_buff_reader_if;
    logic               erx_en;
    logic               ibuff_flag;
    logic signed [31:0] iram_data_out;
    logic               oram_r_enable;
    logic [9:0]         oram_r_address;
    logic signed [31:0] osample;
    logic [6:0]         osample_index;
    logic               osample_valid;
    logic               isample_ready;
    logic               olast;
    logic signed [31:0] opeak;
    logic [6:0]         opeak_index;
    logic               opeak_valid;
    logic               obusy;
    logic               ooverrun;

    modport slave (
        input  erx_en, ibuff_flag, iram_data_out, isample_ready,
        output oram_r_enable, oram_r_address, osample, osample_index, osample_valid,
        output olast, opeak, opeak_index, opeak_valid, obusy, ooverrun
    );

    modport master (
        output erx_en, ibuff_flag, iram_data_out, isample_ready,
        input  oram_r_enable, oram_r_address, osample, osample_index, osample_valid,
        input  olast, opeak, opeak_index, opeak_valid, obusy, ooverrun
    );
endinterface

// File: rtl/rx_correlator_buff_reader.sv
// Dumps the just-completed 128-word half of a ping-pong BRAM region to a valid/ready sink and tracks its peak.
// First sample appears 3 cycles after the flag toggle. A 2-entry output buffer with read credits absorbs sink stalls.
module rx_correlator_buff_reader #(
    parameter int RAM_BASE_ADDRESS = 0
) (
    input  logic                      crx_clk,
    input  logic                      rrx_rst,
    rx_correlator_buff_reader_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_e;

    localparam logic [9:0] BASE = 10'(RAM_BASE_ADDRESS);

    state_e             state_q, state_d;
    logic               flag_q;
    logic               half_q, half_d;
    logic [6:0]         rd_idx_q, rd_idx_d;
    logic [6:0]         rx_idx_q;
    logic               pend_q;
    logic signed [31:0] dat_q [2];
    logic [6:0]         tag_q [2];
    logic               rd_ptr_q, wr_ptr_q;
    logic [1:0]         cnt_q;
    logic signed [31:0] peak_q;
    logic [6:0]         peak_idx_q;
    logic               peak_vld_q;
    logic               pk_first_q;
    logic               ovr_q;

    logic               toggle, start, out_vld, pop, acc, last_acc, rd_en;
    logic [2:0]         credit;

    assign toggle   = flag_q ^ bus.ibuff_flag;
    assign start    = (state_q == S_IDLE) && bus.erx_en && toggle;
    assign out_vld  = (cnt_q != 2'd0);
    assign pop      = out_vld && bus.isample_ready;
    assign acc      = pop && bus.erx_en;
    assign last_acc = acc && (tag_q[rd_ptr_q] == 7'd127);

    // A slot being drained this cycle is free again, so back-to-back reads keep one sample per cycle.
    assign credit   = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, pend_q};
    assign rd_en    = (state_q == S_READ) && bus.erx_en && (credit < 3'd2);

    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        rd_idx_d = rd_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_READ;
                    half_d   = flag_q;
                    rd_idx_d = '0;
                end
            end
            S_READ: begin
                if (rd_en) begin
                    rd_idx_d = rd_idx_q + 7'd1;
                    if (rd_idx_q == 7'd127) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_acc) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!bus.erx_en) state_d = S_IDLE;
    end

    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            state_q  <= S_IDLE;
            flag_q   <= 1'b0;
            half_q   <= 1'b0;
            rd_idx_q <= '0;
            pend_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            flag_q   <= bus.ibuff_flag;
            half_q   <= half_d;
            rd_idx_q <= rd_idx_d;
            pend_q   <= rd_en;
            if (!bus.erx_en) ovr_q <= 1'b0;
            else if (toggle && (state_q != S_IDLE)) ovr_q <= 1'b1;
        end
    end

    // Reads return in order, so the returning index is a simple counter.
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            for (int i = 0; i < 2; i++) begin
                dat_q[i] <= '0;
                tag_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= '0;
            rx_idx_q <= '0;
        end else if (!bus.erx_en) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (start) rx_idx_q <= '0;
            if (pend_q) begin
                dat_q[wr_ptr_q] <= bus.iram_data_out;
                tag_q[wr_ptr_q] <= rx_idx_q;
                wr_ptr_q        <= ~wr_ptr_q;
                rx_idx_q        <= rx_idx_q + 7'd1;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, pend_q} - {1'b0, pop};
        end
    end

    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            peak_q     <= '0;
            peak_idx_q <= '0;
            peak_vld_q <= 1'b0;
            pk_first_q <= 1'b0;
        end else begin
            peak_vld_q <= last_acc;
            if (start) begin
                pk_first_q <= 1'b1;
            end else if (acc) begin
                pk_first_q <= 1'b0;
                if (pk_first_q || (dat_q[rd_ptr_q] > peak_q)) begin
                    peak_q     <= dat_q[rd_ptr_q];
                    peak_idx_q <= tag_q[rd_ptr_q];
                end
            end
        end
    end

    assign bus.oram_r_enable  = rd_en;
    assign bus.oram_r_address = rd_en ? (BASE + {2'b00, half_q, rd_idx_q}) : 10'd0;
    assign bus.osample        = dat_q[rd_ptr_q];
    assign bus.osample_index  = tag_q[rd_ptr_q];
    assign bus.osample_valid  = out_vld;
    assign bus.olast          = out_vld && (tag_q[rd_ptr_q] == 7'd127);
    assign bus.opeak          = peak_q;
    assign bus.opeak_index    = peak_idx_q;
    assign bus.opeak_valid    = peak_vld_q;
    assign bus.obusy          = (state_q != S_IDLE);
    assign bus.ooverrun       = ovr_q;
endmodule

// File: doc/rx_correlator_buff_reader.md
RX_CORRELATOR_BUFF_READER -- requirements
Module: rx_correlator_buff_reader

Interface
REQ-001 SHALL have parameter RAM_BASE_ADDRESS, default 0: base word address of this unit's 256-word ping-pong region in the shared BRAM.
REQ-002 SHALL have port crx_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rrx_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port erx_en  input  1  enable; low = synchronous abort/clear.
REQ-005 SHALL have port ibuff_flag  input  1  writer's current half select; flag=0 writes base+0..127, flag=1 writes base+128..255.
REQ-006 SHALL have port iram_data_out  input  32 signed  BRAM read data, valid one cycle after oram_r_enable.
REQ-007 SHALL have port oram_r_enable  output  1  BRAM read strobe.
REQ-008 SHALL have port oram_r_address  output  10  BRAM read address.
REQ-009 SHALL have port osample  output  32 signed  dumped correlation sample.
REQ-010 SHALL have port osample_index  output  7  position of osample within the half (0..127).
REQ-011 SHALL have port osample_valid  output  1  osample/osample_index/olast valid.
REQ-012 SHALL have port isample_ready  input  1  downstream accepts when high with osample_valid.
REQ-013 SHALL have port olast  output  1  marks index 127.
REQ-014 SHALL have ports opeak (output 32 signed), opeak_index (output 7), opeak_valid (output 1): maximum of completed dump.
REQ-015 SHALL have ports obusy (output 1) dump in progress, ooverrun (output 1) sticky missed-buffer flag.

Function
REQ-016 SHALL register ibuff_flag every cycle (including when idle/disabled); toggle = registered value differs from input.
REQ-017 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-018 IDLE: on toggle, SHALL latch completed-half offset = 128 if old flag value was 1, else 0; go to READ; obusy high from the next cycle.
REQ-019 READ: SHALL issue reads at offset+RAM_BASE_ADDRESS+index, index 0..127 ascending, address arithmetic modulo 1024.
REQ-020 SHALL issue a read only when (output-buffer occupancy + reads in flight) < 2; output buffer holds 2 entries.
REQ-021 With isample_ready held high, SHALL sustain one sample per cycle; first oram_r_enable one cycle after toggle sampled; first osample_valid two cycles after first oram_r_enable.
REQ-022 After the read of index 127 SHALL go to DRAIN; oram_r_enable low in DRAIN and IDLE.
REQ-023 DRAIN: after the index-127 sample is accepted SHALL return to IDLE; obusy low the following cycle.
REQ-024 osample, osample_index, olast SHALL remain stable while osample_valid high and isample_ready low.
REQ-025 olast SHALL be high exactly when osample_valid high and osample_index = 127.
REQ-026 opeak SHALL track accepted samples, updating only on strictly greater signed value (first occurrence wins); first accepted sample always loads.
REQ-027 opeak_valid SHALL pulse one cycle, the cycle after the index-127 accept; opeak/opeak_index hold until next dump's first accept.
REQ-028 Toggle while not IDLE SHALL set ooverrun and be ignored; current dump continues unchanged.
REQ-029 Toggle in the same cycle the FSM returns to IDLE SHALL count as overrun (not started).
REQ-030 erx_en low SHALL, next edge: FSM to IDLE, flush buffer and in-flight reads, clear osample_valid, obusy, opeak_valid, ooverrun; toggles ignored while low.

Reset
REQ-031 rrx_rst high SHALL asynchronously force: FSM IDLE; oram_r_enable 0; oram_r_address 0; osample 0; osample_index 0; osample_valid 0; olast 0; opeak 0; opeak_index 0; opeak_valid 0; obusy 0; ooverrun 0; registered flag 0.
REQ-032 Reset mid-dump SHALL abort; no dump resumes after release without a new toggle.

Verification
REQ-033 RAM_BASE_ADDRESS=256, flag 0->1, ready=1 -> reads 256..383, 128 samples back-to-back, olast at index 127.
REQ-034 Flag 1->0, RAM word base+128+k = k-64 -> addresses base+128..base+255; opeak=63, opeak_index=127, opeak_valid one pulse.
REQ-035 Ready toggled 1-of-3 cycles -> no sample lost/duplicated, indexes 0..127 in order, never >2 outstanding.
REQ-036 Second toggle at sample 50 -> ooverrun=1, dump completes all 128; erx_en low then -> ooverrun=0, IDLE.
REQ-037 Async rrx_rst at index 70 -> all outputs zero immediately; no reads after release until new toggle.
REQ-038 Equal maxima 500 at indexes 10 and 90 -> opeak=500, opeak_index=10.
